// File: rtl/bit_index_iter.sv
// Serialises the set-bit positions of a BW-bit vector into one index per beat, lowest or highest first.
// Latency 1 cycle from accept to first beat; out_rdy low holds the beat; in_rdy rises only on IDLE or a consumed last beat.
// Optional BIT_INDEX_ITER_POPCNT_EN adds out_rem, a registered count of the set bits still to be emitted.
module bit_index_iter #(
    parameter int  BW        = 8,
    parameter bit  MSB_FIRST = 1'b0,
    localparam int IW        = $clog2(BW)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [BW-1:0] in_vec,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          out_empty
`ifdef BIT_INDEX_ITER_POPCNT_EN
    ,
    output logic [IW:0]   out_rem
`endif
);

    localparam logic [BW-1:0] ONE = BW'(1);

    typedef enum logic {IDLE, ITER} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] vec_reg, vec_nxt;
    logic          empty_q, empty_nxt;
    logic [IW-1:0] sel_idx;
    logic          last_raw;
    logic          accept;
    logic          beat;

    // Later matches overwrite earlier ones, so the loop direction sets priority.
    always_comb begin
        sel_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < BW; i++)
                if (vec_reg[i]) sel_idx = IW'(i);
        end else begin
            for (int i = BW - 1; i >= 0; i--)
                if (vec_reg[i]) sel_idx = IW'(i);
        end
    end

`ifdef BIT_INDEX_ITER_POPCNT_EN
    localparam int RW = IW + 1;
    logic [IW:0] rem_q, rem_nxt;

    assign last_raw = empty_q | (rem_q == RW'(1));
    assign out_rem  = out_vld ? rem_q : '0;

    always_comb begin
        rem_nxt = rem_q;
        if (accept)
            rem_nxt = RW'($countones(in_vec));
        else if (beat && rem_q != '0)
            rem_nxt = rem_q - RW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_b) rem_q <= '0;
        else        rem_q <= rem_nxt;
    end
`else
    assign last_raw = empty_q | ((vec_reg & (vec_reg - ONE)) == '0);
`endif

    assign out_vld   = (state == ITER);
    assign out_idx   = out_vld ? sel_idx : '0;
    assign out_last  = out_vld & last_raw;
    assign out_empty = out_vld & empty_q;
    assign beat      = out_vld & out_rdy;
    // Combinational from out_rdy so a new vector can load on the last-beat edge.
    assign in_rdy    = rst_b & ((state == IDLE) | (beat & out_last));
    assign accept    = in_vld & in_rdy;

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec_reg;
        empty_nxt = empty_q;
        if (accept) begin
            vec_nxt   = in_vec;
            empty_nxt = (in_vec == '0);
            state_nxt = ITER;
        end else if (beat) begin
            vec_nxt = vec_reg & ~(ONE << sel_idx);
            if (out_last) state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state   <= IDLE;
            vec_reg <= '0;
            empty_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            vec_reg <= vec_nxt;
            empty_q <= empty_nxt;
        end
    end

endmodule
